// File: rtl/timer_counter_pkg.sv
// ---------------------------------------------------------------------------
// timer_counter_pkg
// Shared definitions for the timer/counter peripheral:
//   - system base addresses of the two timer instances (TC1, TC2)
//   - register offsets decoded from Addr[3:2]
//   - FSM state encodings and CTRL.Mode encodings
//   - packed layout of the 4-bit CTRL register
// ---------------------------------------------------------------------------
package timer_counter_pkg;

    // Address windows of the two instances; the bridge gates WE by range.
    localparam logic [31:0] TC1_BASE_A = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE_B = 32'h0000_7F0B;
    localparam logic [31:0] TC2_BASE_A = 32'h0000_7F10;
    localparam logic [31:0] TC2_BASE_B = 32'h0000_7F1B;

    // Register offsets as seen on Addr[3:2].
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // CTRL.Mode encodings; 10 and 11 behave as one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // CTRL register: bit3 IM, bits2:1 Mode, bit0 Enable.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       enable;
    } ctrl_t;

endpackage : timer_counter_pkg

// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
// Memory-mapped down-counter with one-shot and auto-reload modes.
//
// Ports:
//   clk    in   1   single clock, all state updates on the rising edge
//   reset  in   1   synchronous, active-high reset
//   Addr   in  32   bus address, only Addr[3:2] is decoded
//   WE     in   1   word write strobe (aligned stores only)
//   Din    in  32   write data
//   Dout   out 32   combinational read data for Addr[3:2]
//   IRQ    out  1   interrupt request (irq_flag masked by CTRL.IM)
//
// Registers: CTRL (offset 0, 4 bits), PRESET (offset 1), COUNT (offset 2,
// read-only), offset 3 reserved and reads as zero.
// ---------------------------------------------------------------------------
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    ctrl_t       ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic [1:0]  state;

    logic [1:0]  reg_sel;
    assign reg_sel = Addr[3:2];

    // Word-aligned, window-decoded by the bridge: the other address bits
    // carry no information for this block.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Addr[31:4], Addr[1:0]};

    // NOTE: every register below is written with non-blocking assignments so
    // all of them see the pre-edge values of each other within a clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl.enable)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl.enable) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // Covers COUNT==0 too, so PRESET=0 never wraps.
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (ctrl.mode == MODE_RELOAD) begin
                        irq_flag <= 1'b0;
                    end else begin
                        // One-shot: flag stays up until software writes CTRL.
                        ctrl.enable <= 1'b0;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // NOTE: the bus write is placed after the FSM on purpose; for the
            // same register the later non-blocking assignment wins, so a CPU
            // CTRL write overrides the FSM clearing Enable or setting the flag.
            if (WE) begin
                case (reg_sel)
                    REG_CTRL: begin
                        ctrl     <= ctrl_t'(Din[3:0]);
                        irq_flag <= 1'b0;
                    end
                    REG_PRESET: preset <= Din;
                    default: ;  // COUNT is read-only, offset 3 reserved
                endcase
            end
        end
    end

    // NOTE: Dout gets a default before the case so no latch is inferred for
    // the undecoded offsets.
    always_comb begin
        Dout = '0;
        case (reg_sel)
            REG_CTRL:   Dout = {28'b0, ctrl};
            REG_PRESET: Dout = preset;
            REG_COUNT:  Dout = count;
            default:    Dout = '0;
        endcase
    end

    assign IRQ = irq_flag & ctrl.im;

endmodule : timer_counter

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter
// Directed self-checking bench for timer_counter. Inputs change and outputs
// are sampled 1 ns after the rising edge; "En" below means the state just
// after the n-th rising edge following the CTRL write that starts a run.
// ---------------------------------------------------------------------------
module tb_timer_counter;
    import timer_counter_pkg::*;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(tag, Dout, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Expected COUNT / IRQ after E1..En for the directed runs.
    logic [31:0] m0_count [6]  = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    logic        m0_irq   [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] m1_count [11] = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0,
                                   32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
    logic        m1_irq   [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int irq_seen;
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;

        // ---- reset wins over a simultaneous CTRL / PRESET write ----------
        Addr = A_CTRL; Din = 32'hF; WE = 1'b1;
        step();
        Addr = A_PRESET; Din = 32'h1234;
        step();
        WE = 1'b0; reset = 1'b0;
        check_reg("rst_ctrl",   A_CTRL,   32'h0);
        check_reg("rst_preset", A_PRESET, 32'h0);
        check_reg("rst_count",  A_COUNT,  32'h0);
        check("rst_irq", {31'b0, IRQ}, 32'd0);

        // ---- mode 0: PRESET=3, CTRL=0x9 -----------------------------------
        do_reset();
        wr(A_PRESET, 32'd3);
        wr(A_CTRL,   32'h9);
        for (int k = 0; k < 6; k++) begin
            step();
            check_reg($sformatf("m0_count_E%0d", k + 1), A_COUNT, m0_count[k]);
            check($sformatf("m0_irq_E%0d", k + 1), {31'b0, IRQ}, {31'b0, m0_irq[k]});
        end
        check_reg("m0_ctrl_after_int", A_CTRL, 32'h8);
        step(); step(); step();
        check("m0_irq_held", {31'b0, IRQ}, 32'd1);

        // ---- mode 0 acknowledge --------------------------------------------
        wr(A_CTRL, 32'h0);
        check("ack_irq", {31'b0, IRQ}, 32'd0);
        check_reg("ack_count", A_COUNT, 32'h0);
        step();
        check_reg("ack_count_hold", A_COUNT, 32'h0);

        // ---- mode 1 auto-reload: PRESET=2, CTRL=0xB ------------------------
        do_reset();
        wr(A_PRESET, 32'd2);
        wr(A_CTRL,   32'hB);
        for (int k = 0; k < 11; k++) begin
            step();
            check_reg($sformatf("m1_count_E%0d", k + 1), A_COUNT, m1_count[k]);
            check($sformatf("m1_irq_E%0d", k + 1), {31'b0, IRQ}, {31'b0, m1_irq[k]});
        end
        check_reg("m1_ctrl_kept", A_CTRL, 32'hB);

        // ---- mask and read-only: CTRL=0x1, PRESET=1 ------------------------
        do_reset();
        wr(A_PRESET, 32'd1);
        wr(A_CTRL,   32'h1);
        irq_seen = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (IRQ) irq_seen++;
        end
        check("mask_flag_set", {31'b0, dut.irq_flag}, 32'd1);
        step();
        if (IRQ) irq_seen++;
        check("mask_irq_never", irq_seen, 32'd0);
        check_reg("mask_ctrl_en_cleared", A_CTRL, 32'h0);
        wr(A_COUNT, 32'hFFFF);
        check_reg("ro_count",  A_COUNT,  32'h0);
        check_reg("ro_ctrl",   A_CTRL,   32'h0);
        check_reg("ro_preset", A_PRESET, 32'h1);
        wr(A_RSVD, 32'hFFFF);
        check_reg("rsvd_reads_zero", A_RSVD,   32'h0);
        check_reg("rsvd_preset",     A_PRESET, 32'h1);

        // ---- reset mid-count: PRESET=100, CTRL=0x9, reset at COUNT=50 ------
        do_reset();
        wr(A_PRESET, 32'd100);
        wr(A_CTRL,   32'h9);
        irq_seen = 0;
        for (int k = 0; k < 52; k++) begin
            step();
            if (IRQ) irq_seen++;
        end
        check_reg("mid_count_50", A_COUNT, 32'd50);
        do_reset();
        check_reg("mid_ctrl",   A_CTRL,   32'h0);
        check_reg("mid_preset", A_PRESET, 32'h0);
        check_reg("mid_count",  A_COUNT,  32'h0);
        check("mid_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
        for (int k = 0; k < 10; k++) begin
            step();
            if (IRQ) irq_seen++;
        end
        check("mid_irq_never", irq_seen, 32'd0);
        check_reg("mid_count_idle", A_COUNT, 32'h0);

        // ---- PRESET=0 reaches INT without underflow ------------------------
        do_reset();
        wr(A_CTRL, 32'h9);
        step(); step();
        check("p0_irq_E2", {31'b0, IRQ}, 32'd0);
        step();
        check("p0_irq_E3", {31'b0, IRQ}, 32'd1);
        check_reg("p0_count", A_COUNT, 32'h0);
        check("p0_state", {30'b0, dut.state}, {30'b0, ST_INT});

        // ---- CTRL write on the edge the FSM clears Enable: write wins ------
        wr(A_CTRL, 32'h9);
        check_reg("race_ctrl", A_CTRL, 32'h9);
        check("race_irq", {31'b0, IRQ}, 32'd0);

        // ---- mode 10 behaves as one-shot ------------------------------------
        do_reset();
        wr(A_CTRL, 32'hD);
        step(); step(); step();
        check("m2_irq_E3", {31'b0, IRQ}, 32'd1);
        step();
        check_reg("m2_ctrl_en_cleared", A_CTRL, 32'hC);
        step(); step();
        check("m2_irq_held", {31'b0, IRQ}, 32'd1);

        // ---- PRESET rewritten during CNT: current run uses old value -------
        do_reset();
        wr(A_PRESET, 32'd4);
        wr(A_CTRL,   32'hB);
        step(); step();
        check_reg("pw_count_E2", A_COUNT, 32'd4);
        wr(A_PRESET, 32'd9);
        check_reg("pw_count_E3", A_COUNT, 32'd3);
        step(); step();
        check_reg("pw_count_E5", A_COUNT, 32'd1);
        step();
        check_reg("pw_count_E6", A_COUNT, 32'd0);
        check("pw_irq_E6", {31'b0, IRQ}, 32'd1);
        step(); step(); step();
        check_reg("pw_reload_new", A_COUNT, 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_timer_counter

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL have no parameters; widths and addresses SHALL come from the shared definitions file.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Addr  input  32  bus address; only Addr[3:2] SHALL be decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved).
REQ-005 WE  input  1  word write strobe from the store path; the store path only asserts it for aligned word stores.
REQ-006 Din  input  32  write data.
REQ-007 Dout  output  32  combinational read data for Addr[3:2].
REQ-008 IRQ  output  1  interrupt request to the CP0 hardware-interrupt input.

Function
REQ-009 Registers: CTRL[3:0] holds bit0 Enable, bits2:1 Mode, and bit3 IM (interrupt mask); PRESET is 32 bits; COUNT is 32 bits.
REQ-010 A write with WE=1 SHALL update CTRL at Addr[3:2]=0 (Din[3:0] only) or PRESET at 1; writes at 2 or 3 SHALL be ignored, because COUNT is read-only.
REQ-011 Dout SHALL be {28'b0,CTRL} at 0, PRESET at 1, COUNT at 2, and 0 at 3.
REQ-012 FSM states: IDLE, LOAD, CNT, INT.
REQ-013 IDLE: if CTRL.Enable=1, go to LOAD; otherwise stay and hold COUNT.
REQ-014 LOAD: COUNT <= PRESET, then go to CNT.
REQ-015 CNT, Enable=0: go to IDLE and hold COUNT.
REQ-016 CNT, Enable=1, COUNT>1: COUNT <= COUNT-1 and stay in CNT.
REQ-017 CNT, Enable=1, COUNT<=1: COUNT <= 0, set irq_flag, and go to INT.
REQ-018 INT, Mode=00: clear CTRL.Enable, go to IDLE, and keep irq_flag set until the next CTRL write.
REQ-019 INT, Mode=01 (auto-reload): go to IDLE and clear irq_flag, so the flag is a 1-cycle pulse; counting then restarts through LOAD.
REQ-020 Mode values 10 and 11 SHALL behave as mode 00.
REQ-021 IRQ SHALL equal irq_flag & CTRL.IM.
REQ-022 Any CTRL write SHALL clear irq_flag.
REQ-023 A CPU CTRL write on the same edge that the FSM clears Enable in INT SHALL win, with the written value taking effect.
REQ-024 A PRESET write during CNT SHALL NOT change COUNT and SHALL take effect at the next LOAD.
REQ-025 PRESET=0 SHALL reach INT on the first CNT cycle, with no underflow to 0xFFFFFFFF.
REQ-026 COUNT arithmetic SHALL be unsigned 32-bit and SHALL never wrap.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL set CTRL=0, PRESET=0, COUNT=0, irq_flag=0, and state=IDLE; IRQ SHALL be 0 in the following cycle.
REQ-028 A reset asserted mid-count SHALL abort counting without raising IRQ.
REQ-029 Reset SHALL take priority over a simultaneous WE.

Structure
REQ-030 The shared definitions file SHALL hold the timer base addresses (TC1a/TC1b, TC2a/TC2b), the register offsets, the FSM state encodings, and the mode encodings.
REQ-031 No sub-module is needed; the system SHALL instantiate timer_counter twice (TC1, TC2) behind the bridge, which gates WE by address range.

Verification
REQ-032 Mode 0: write PRESET=3, then CTRL=0x9 -> COUNT reads 3,2,1,0; IRQ rises 5 edges after the CTRL-write edge and stays 1; CTRL reads 0x8.
REQ-033 Mode 0 acknowledge: with IRQ held, write CTRL=0x0 -> IRQ=0 on the next cycle and COUNT stays 0.
REQ-034 Mode 1: PRESET=2, CTRL=0xB -> a 1-cycle IRQ pulse every 5 cycles, repeating, with COUNT cycling 2,1,0.
REQ-035 Mask and read-only: CTRL=0x1, PRESET=1 -> irq_flag sets but IRQ stays 0; a write of 0xFFFF to COUNT leaves COUNT unchanged.
REQ-036 Reset mid-count: PRESET=100, CTRL=0x9, reset at COUNT=50 -> all registers read 0, the FSM is in IDLE, and IRQ never asserts.
REQ-037 Edge cases: PRESET=0 with Enable=1 -> INT reached with COUNT=0; PRESET rewritten during CNT -> the current run completes with the old value.
